// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the alu_v3 fixed-point ALU: opcode enum,
//               pipeline stage record and an opcode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Widest operand a stage record can carry. Operands are stored
    // sign-extended to this width; alu_v3 only uses the low BUS_WIDTH bits.
    localparam int ALU_MAX_W = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_MAC  = 3'd3,
        OP_ADDE = 3'd4
    } alu_op_e;

    // The opcode is kept as raw bits so that reserved codes (5-7) survive
    // the pipeline and can have their overflow flag suppressed in S3.
    typedef struct packed {
        logic                 valid;
        logic [2:0]           op;
        logic                 f_clr;
        logic [ALU_MAX_W-1:0] a;
        logic [ALU_MAX_W-1:0] b;
    } alu_stage_t;

    function automatic logic is_reserved(input logic [2:0] op);
        return (op > 3'(OP_ADDE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_round.sv
`default_nettype none
// ============================================================================
// Module      : sat_round
// Description : Combinational arithmetic right shift with round-half-up,
//               followed by saturation to a narrower signed width.
// Ports       : din  - signed input, IN_W bits
//               dout - rounded, shifted, saturated output, OUT_W bits
//               ovf  - high when saturation clipped the value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_round #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    // One guard bit so the rounding increment can never wrap.
    localparam int EXT_W = IN_W + 1;

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_rnd;
    logic signed [EXT_W-1:0] w_shr;
    logic [EXT_W-OUT_W:0]    w_hi;
    logic                    w_pos_ovf;
    logic                    w_neg_ovf;

    assign w_ext = {din[IN_W-1], din};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [EXT_W-1:0] c_HALF = {{(EXT_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
            assign w_rnd = w_ext + $signed(c_HALF);
        end else begin : g_noround
            assign w_rnd = w_ext;
        end
    endgenerate

    assign w_shr = w_rnd >>> SHIFT;

    // Result fits only if every bit from the output sign bit upward agrees.
    assign w_hi      = w_shr[EXT_W-1:OUT_W-1];
    assign w_pos_ovf = !w_shr[EXT_W-1] && (|w_hi);
    assign w_neg_ovf =  w_shr[EXT_W-1] && !(&w_hi);

    always_comb begin
        dout = w_shr[OUT_W-1:0];
        if (w_pos_ovf) begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (w_neg_ovf) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    assign ovf = w_pos_ovf | w_neg_ovf;

endmodule
`default_nettype wire

// File: rtl/alu_v3.sv
`default_nettype none
// ============================================================================
// Module      : alu_v3
// Description : Pipelined signed fixed-point ALU (ADD/SUB/MUL/MAC/ADDE) with
//               saturating accumulator, valid tracking and overflow flag.
//               Output appears three edges after the capture edge.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid, op         - issue qualifier and opcode
//               data_a, data_b       - register operands
//               imm, sw, f_load      - E operand sources and select
//               f_clr                - MAC: use zero as accumulator base
//               out_valid,result,ovf - saturated result and overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_v3
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8,   // 4 .. ALU_MAX_W
    parameter int FRAC_BITS = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [2:0]           op,
    input  logic [BUS_WIDTH-1:0] data_a,
    input  logic [BUS_WIDTH-1:0] data_b,
    input  logic [BUS_WIDTH-1:0] imm,
    input  logic [BUS_WIDTH-1:0] sw,
    input  logic                 f_load,
    input  logic                 f_clr,
    output logic                 out_valid,
    output logic [BUS_WIDTH-1:0] result,
    output logic                 ovf
);

    localparam int W = BUS_WIDTH;

    // ---------------- S1: operand capture ----------------
    logic [W-1:0] w_e;
    logic [W-1:0] w_b_sel;
    alu_stage_t   r_s1;

    assign w_e     = f_load ? imm : sw;
    assign w_b_sel = (op == OP_ADDE) ? w_e : data_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= in_valid;
            if (in_valid) begin
                r_s1.op    <= op;
                r_s1.f_clr <= f_clr;
                r_s1.a     <= ALU_MAX_W'($signed(data_a));
                r_s1.b     <= ALU_MAX_W'($signed(w_b_sel));
            end
        end
    end

    generate
        if (W < ALU_MAX_W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{r_s1.a[ALU_MAX_W-1:W], r_s1.b[ALU_MAX_W-1:W]};
        end
    endgenerate

    // ---------------- S2: add/sub and rescaled product ----------------
    logic signed [W-1:0]   w_a;
    logic signed [W-1:0]   w_b;
    logic signed [W:0]     w_sum;
    logic signed [2*W-1:0] w_prod;
    logic signed [W-1:0]   w_prod_sat;
    logic                  w_ovf_mul;

    logic                  r_s2_valid;
    logic [2:0]            r_s2_op;
    logic                  r_s2_f_clr;
    logic signed [W:0]     r_s2_sum;
    logic signed [W-1:0]   r_s2_prod;
    logic                  r_s2_ovf_mul;

    assign w_a = r_s1.a[W-1:0];
    assign w_b = r_s1.b[W-1:0];

    always_comb begin
        if (r_s1.op == OP_SUB) begin
            w_sum = {w_a[W-1], w_a} - {w_b[W-1], w_b};
        end else begin
            w_sum = {w_a[W-1], w_a} + {w_b[W-1], w_b};
        end
    end

    assign w_prod = (2*W)'(w_a) * (2*W)'(w_b);

    sat_round #(
        .IN_W  (2*W),
        .OUT_W (W),
        .SHIFT (FRAC_BITS)
    ) u_prod_sat (
        .din  (w_prod),
        .dout (w_prod_sat),
        .ovf  (w_ovf_mul)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_op      <= '0;
            r_s2_f_clr   <= 1'b0;
            r_s2_sum     <= '0;
            r_s2_prod    <= '0;
            r_s2_ovf_mul <= 1'b0;
        end else begin
            r_s2_valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_s2_op      <= r_s1.op;
                r_s2_f_clr   <= r_s1.f_clr;
                r_s2_sum     <= w_sum;
                r_s2_prod    <= w_prod_sat;
                r_s2_ovf_mul <= w_ovf_mul;
            end
        end
    end

    // ---------------- S3: final saturation and accumulator ----------------
    // The whole read-modify-write of acc happens here, so consecutive MACs
    // see each other's results without forwarding.
    logic signed [W-1:0] r_acc;
    logic signed [W-1:0] w_mac_base;
    logic signed [W:0]   w_s3_in;
    logic signed [W-1:0] w_sum_sat;
    logic                w_ovf_sum;
    logic signed [W-1:0] w_res;
    logic                w_ovf;

    logic                r_s3_valid;
    logic [W-1:0]        r_s3_result;
    logic                r_s3_ovf;

    assign w_mac_base = r_s2_f_clr ? '0 : r_acc;
    assign w_s3_in    = (r_s2_op == OP_MAC)
                      ? ({w_mac_base[W-1], w_mac_base} + {r_s2_prod[W-1], r_s2_prod})
                      : r_s2_sum;

    sat_round #(
        .IN_W  (W + 1),
        .OUT_W (W),
        .SHIFT (0)
    ) u_sum_sat (
        .din  (w_s3_in),
        .dout (w_sum_sat),
        .ovf  (w_ovf_sum)
    );

    always_comb begin
        w_res = w_sum_sat;
        w_ovf = w_ovf_sum;
        if (r_s2_op == OP_MUL) begin
            w_res = r_s2_prod;
            w_ovf = r_s2_ovf_mul;
        end else if (r_s2_op == OP_MAC) begin
            w_ovf = r_s2_ovf_mul | w_ovf_sum;
        end else if (is_reserved(r_s2_op)) begin
            w_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_s3_valid  <= 1'b0;
            r_s3_result <= '0;
            r_s3_ovf    <= 1'b0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_result <= w_res;
                r_s3_ovf    <= w_ovf;
                if (r_s2_op == OP_MAC) begin
                    r_acc <= w_sum_sat;
                end
            end
        end
    end

    // ---------------- Output register: holds value across idle cycles ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= r_s3_valid;
            if (r_s3_valid) begin
                result <= r_s3_result;
                ovf    <= r_s3_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_v3.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_v3
// Description : Self-checking bench for alu_v3. Two instances (FRAC_BITS 0
//               and 4) share stimulus; a cycle-indexed issue history feeds an
//               integer reference model evaluated when each op is due out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_v3;

    localparam int W    = 8;
    localparam int HN   = 4096;
    localparam int MAXV = 127;
    localparam int MINV = -128;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] data_a, data_b, imm, sw;
    logic       f_load, f_clr;
    logic       ov0, ovf0, ov1, ovf1;
    logic [7:0] res0, res1;

    alu_v3 #(.BUS_WIDTH(W), .FRAC_BITS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
        .data_a(data_a), .data_b(data_b), .imm(imm), .sw(sw),
        .f_load(f_load), .f_clr(f_clr),
        .out_valid(ov0), .result(res0), .ovf(ovf0)
    );

    alu_v3 #(.BUS_WIDTH(W), .FRAC_BITS(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
        .data_a(data_a), .data_b(data_b), .imm(imm), .sw(sw),
        .f_load(f_load), .f_clr(f_clr),
        .out_valid(ov1), .result(res1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue history, indexed by the edge that captures the issue.
    bit         h_v   [HN];
    logic [2:0] h_op  [HN];
    logic [7:0] h_a   [HN];
    logic [7:0] h_b   [HN];
    logic [7:0] h_imm [HN];
    logic [7:0] h_sw  [HN];
    bit         h_fl  [HN];
    bit         h_fc  [HN];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc0 = 0, acc1 = 0;
    int last_r0 = 0, last_r1 = 0;
    bit last_o0 = 0, last_o1 = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int sat(input int x, output bit o);
        o = (x > MAXV) || (x < MINV);
        return (x > MAXV) ? MAXV : ((x < MINV) ? MINV : x);
    endfunction

    // Reference: plain integer arithmetic straight from the operation rules.
    function automatic void model(input int frac, input int opc, input int a, input int b,
                                  input int e, input bit clr, inout int acc,
                                  output int r, output bit o);
        int p, ps;
        bit om, os;
        p = a * b;
        if (frac > 0) p = (p + (1 << (frac - 1))) >>> frac;
        ps = sat(p, om);
        case (opc)
            0:       r = sat(a + b, o);
            1:       r = sat(a - b, o);
            2:       begin r = ps; o = om; end
            3:       begin
                         r = sat((clr ? 0 : acc) + ps, os);
                         o = om | os;
                         acc = r;
                     end
            4:       r = sat(a + e, o);
            default: begin r = sat(a + b, o); o = 1'b0; end
        endcase
    endfunction

    task automatic check_outputs();
        int idx, r, a, b, e;
        bit o, ev;
        idx = cyc - 3;
        ev  = (idx >= 0) ? h_v[idx] : 1'b0;
        check_val("out_valid_f0", longint'(ov0), longint'(ev));
        check_val("out_valid_f4", longint'(ov1), longint'(ev));
        if (ev) begin
            a = int'($signed(h_a[idx]));
            b = int'($signed(h_b[idx]));
            e = h_fl[idx] ? int'($signed(h_imm[idx])) : int'($signed(h_sw[idx]));
            model(0, int'(h_op[idx]), a, b, e, h_fc[idx], acc0, r, o);
            last_r0 = r; last_o0 = o;
            model(4, int'(h_op[idx]), a, b, e, h_fc[idx], acc1, r, o);
            last_r1 = r; last_o1 = o;
        end
        check_val("result_f0", longint'($signed(res0)), longint'(last_r0));
        check_val("ovf_f0",    longint'(ovf0),          longint'(last_o0));
        check_val("result_f4", longint'($signed(res1)), longint'(last_r1));
        check_val("ovf_f4",    longint'(ovf1),          longint'(last_o1));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic issue(input bit v, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] im, input logic [7:0] s,
                         input bit fl, input bit fc);
        in_valid = v; op = o; data_a = a; data_b = b; imm = im; sw = s;
        f_load = fl; f_clr = fc;
        h_v[cyc+1] = v;  h_op[cyc+1] = o;   h_a[cyc+1]  = a; h_b[cyc+1] = b;
        h_imm[cyc+1] = im; h_sw[cyc+1] = s; h_fl[cyc+1] = fl; h_fc[cyc+1] = fc;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 3'($urandom), 8'($urandom), 8'($urandom),
                         8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Reset mid-flight: every issue not yet out is lost, acc and outputs clear.
    task automatic reset_mid();
        rst_n = 1'b0;
        for (int i = cyc - 2; i <= cyc + 1; i++) if (i >= 0) h_v[i] = 1'b0;
        acc0 = 0; acc1 = 0;
        last_r0 = 0; last_r1 = 0; last_o0 = 0; last_o1 = 0;
        idle(1);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] edges [4];
        edges[0] = 8'h80; edges[1] = 8'h7F; edges[2] = 8'h00; edges[3] = 8'hFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; data_a = '0; data_b = '0;
        imm = '0; sw = '0; f_load = 1'b0; f_clr = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Saturating add/sub, E-operand select, reserved opcode.
        issue(1, 3'd0, 8'd100, 8'd50, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd0, 8'd20,  8'd30, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd1, 8'h9C,  8'd50, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd4, 8'd5,   8'h55, 8'd7,  8'h33, 1, 0);
        issue(1, 3'd4, 8'd5,   8'h55, 8'd7,  8'hFD, 0, 0);
        // Fixed-point multiply, rounding and most-negative squared.
        issue(1, 3'd2, 8'h18,  8'h28, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd2, 8'h01,  8'h08, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd2, 8'h80,  8'h80, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd5, 8'd100, 8'd100, 8'h00, 8'h00, 0, 0);
        idle(4);

        // Back-to-back MACs, then one with an ADD interleaved.
        issue(1, 3'd3, 8'd3, 8'd4, 8'h00, 8'h00, 0, 1);
        issue(1, 3'd3, 8'd2, 8'd5, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd3, 8'd1, 8'd1, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd3, 8'd2, 8'd2, 8'h00, 8'h00, 0, 1);
        issue(1, 3'd0, 8'd1, 8'd1, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd3, 8'd1, 8'd1, 8'h00, 8'h00, 0, 0);
        // Accumulator saturation and recovery; f_clr over saturated acc.
        issue(1, 3'd3, 8'd10, 8'd12, 8'h00, 8'h00, 0, 1);
        issue(1, 3'd3, 8'd3,  8'd4,  8'h00, 8'h00, 0, 0);
        issue(1, 3'd3, 8'd1,  8'hF6, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd3, 8'd100, 8'd2, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd3, 8'd3,  8'd4,  8'h00, 8'h00, 0, 1);
        idle(4);

        // Reset with two ops in flight; acc must restart from zero.
        issue(1, 3'd0, 8'd1, 8'd2, 8'h00, 8'h00, 0, 0);
        issue(1, 3'd3, 8'd5, 8'd5, 8'h00, 8'h00, 0, 1);
        reset_mid();
        idle(3);
        issue(1, 3'd3, 8'd2, 8'd3, 8'h00, 8'h00, 0, 0);
        idle(4);

        // Randomized traffic with boundary-biased operands.
        for (int i = 0; i < 600; i++) begin
            issue($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick(),
                  pick(), pick(), 1'($urandom), $urandom_range(0, 3) == 0);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
